// File: rtl/audio_synth.sv
`default_nettype none
// ============================================================================
//  Module      : audio_synth
//  Description : Stepped-scale square-wave synthesiser; up to four detuned
//                voices mixed into a single first-order PDM output bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_synth #(
    parameter int VOICES     = 2,
    parameter int STEP_WIDTH = 22,
    parameter int OCT_MAX    = 5,
    parameter int INTERVAL   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] audio_select,
    input  logic [6:0] hold_note,
    output logic       audio_out,
    output logic       step_strobe,
    output logic [6:0] note_idx
);
    localparam int               OCT_W      = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1;
    localparam logic [6:0]       c_top_note = 7'(12 * (OCT_MAX + 1) - 1);
    localparam logic [OCT_W-1:0] c_top_oct  = OCT_W'(OCT_MAX);

    localparam logic [1:0] c_mute = 2'd0;
    localparam logic [1:0] c_up   = 2'd1;
    localparam logic [1:0] c_down = 2'd2;
    localparam logic [1:0] c_hold = 2'd3;

    function automatic logic [8:0] period_of(input logic [3:0] semi);
        case (semi)
            4'd0:    period_of = 9'd511;
            4'd1:    period_of = 9'd480;
            4'd2:    period_of = 9'd455;
            4'd3:    period_of = 9'd430;
            4'd4:    period_of = 9'd405;
            4'd5:    period_of = 9'd383;
            4'd6:    period_of = 9'd361;
            4'd7:    period_of = 9'd341;
            4'd8:    period_of = 9'd322;
            4'd9:    period_of = 9'd303;
            4'd10:   period_of = 9'd286;
            4'd11:   period_of = 9'd270;
            default: period_of = 9'd511;
        endcase
    endfunction

    logic [STEP_WIDTH-1:0] r_tempo;
    logic                  r_strobe;
    logic                  w_step;
    logic [3:0]            r_semi, w_semi_nx;
    logic [OCT_W-1:0]      r_oct, w_oct_nx;
    logic [1:0]            r_mode;
    logic                  r_armed;
    logic [6:0]            w_hold_clamp;
    logic [3:0]            w_hold_semi;
    logic [OCT_W-1:0]      w_hold_oct;
    logic [6:0]            w_note_nx;
    logic                  w_run;
    logic [VOICES-1:0]     w_squares;
    logic [2:0]            w_sum, w_t, r_acc;
    logic                  r_out;

    assign w_step = &r_tempo;

    // Split the clamped hold note into octave/semitone by compare-and-subtract.
    always_comb begin
        w_hold_clamp = (hold_note > c_top_note) ? c_top_note : hold_note;
        w_hold_semi  = w_hold_clamp[3:0];
        w_hold_oct   = '0;
        for (int o = 1; o <= OCT_MAX; o++) begin
            if (w_hold_clamp >= 7'(12 * o)) begin
                w_hold_oct  = OCT_W'(o);
                w_hold_semi = 4'(w_hold_clamp - 7'(12 * o));
            end
        end
    end

    always_comb begin
        w_semi_nx = r_semi;
        w_oct_nx  = r_oct;
        if (w_step) begin
            case (audio_select)
                c_up: begin
                    if (r_mode != c_up) begin
                        w_semi_nx = 4'd0;
                        w_oct_nx  = '0;
                    end else if (r_semi == 4'd11) begin
                        w_semi_nx = 4'd0;
                        w_oct_nx  = (r_oct == c_top_oct) ? '0 : r_oct + OCT_W'(1);
                    end else begin
                        w_semi_nx = r_semi + 4'd1;
                    end
                end
                c_down: begin
                    if (r_mode != c_down) begin
                        w_semi_nx = 4'd11;
                        w_oct_nx  = c_top_oct;
                    end else if (r_semi == 4'd0) begin
                        w_semi_nx = 4'd11;
                        w_oct_nx  = (r_oct == '0) ? c_top_oct : r_oct - OCT_W'(1);
                    end else begin
                        w_semi_nx = r_semi - 4'd1;
                    end
                end
                c_hold: begin
                    w_semi_nx = w_hold_semi;
                    w_oct_nx  = w_hold_oct;
                end
                default: ;
            endcase
        end
    end

    // The mode register powers up as "ascending" so that an ascending run from
    // reset simply continues upward from note 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tempo  <= '0;
            r_strobe <= 1'b0;
            r_semi   <= '0;
            r_oct    <= '0;
            r_mode   <= c_up;
            r_armed  <= 1'b0;
        end else begin
            r_tempo  <= r_tempo + STEP_WIDTH'(1);
            r_strobe <= w_step;
            r_semi   <= w_semi_nx;
            r_oct    <= w_oct_nx;
            if (w_step) begin
                r_mode  <= audio_select;
                r_armed <= 1'b1;
            end
        end
    end

    assign w_note_nx = 7'(w_oct_nx) * 7'd12 + 7'(w_semi_nx);
    assign w_run     = r_armed && (r_mode != c_mute);

    for (genvar k = 0; k < VOICES; k++) begin : g_voice
        localparam int         OFS        = k * INTERVAL;
        localparam logic [4:0] c_semi_add = 5'(OFS % 12);
        localparam int         OCT_ADD    = OFS / 12;

        logic [4:0]       w_semi_sum;
        logic             w_carry;
        logic [3:0]       w_vsemi;
        logic [OCT_W-1:0] w_voct;
        logic             w_silent;
        logic [8:0]       w_per_ld;
        logic [7:0]       w_pre_ld;
        logic [8:0]       r_per;
        logic [7:0]       r_pre;
        logic             r_sq;

        assign w_semi_sum = {1'b0, w_semi_nx} + c_semi_add;
        assign w_carry    = (w_semi_sum >= 5'd12);
        assign w_vsemi    = w_carry ? 4'(w_semi_sum - 5'd12) : w_semi_sum[3:0];
        assign w_voct     = OCT_W'(int'(w_oct_nx) + OCT_ADD + int'(w_carry));
        assign w_silent   = (int'(w_note_nx) + OFS) > int'(c_top_note);
        assign w_per_ld   = period_of(w_vsemi);
        assign w_pre_ld   = 8'hFF >> w_voct;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_per <= '0;
                r_pre <= '0;
                r_sq  <= 1'b0;
            end else if (audio_select == c_mute) begin
                r_sq <= 1'b0;
            end else if (w_step) begin
                r_per <= w_per_ld;
                r_pre <= w_pre_ld;
                if (w_silent) begin
                    r_sq <= 1'b0;
                end
            end else if (w_silent) begin
                r_sq <= 1'b0;
            end else if (w_run) begin
                if (r_per == '0) begin
                    r_per <= w_per_ld;
                    if (r_pre == '0) begin
                        r_pre <= w_pre_ld;
                        r_sq  <= ~r_sq;
                    end else begin
                        r_pre <= r_pre - 8'd1;
                    end
                end else begin
                    r_per <= r_per - 9'd1;
                end
            end
        end

        assign w_squares[k] = r_sq;
    end

    // First-order sigma-delta: residue always stays below VOICES.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < VOICES; k++) begin
            w_sum = w_sum + 3'(w_squares[k]);
        end
        w_t = r_acc + w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_out <= 1'b0;
        end else if (w_t >= 3'(VOICES)) begin
            r_acc <= w_t - 3'(VOICES);
            r_out <= 1'b1;
        end else begin
            r_acc <= w_t;
            r_out <= 1'b0;
        end
    end

    assign audio_out   = r_out;
    assign step_strobe = r_strobe;
    assign note_idx    = 7'(r_oct) * 7'd12 + 7'(r_semi);

endmodule
`default_nettype wire

// File: tb/tb_audio_synth.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_synth
//  Description : Directed self-checking bench for audio_synth (fast tempo
//                instance for note sequencing, slow instances for tone timing).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_synth;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_n_s;
    logic [1:0] sel, sel_s1, sel_s2;
    logic [6:0] hold, hold_s1, hold_s2;
    logic       out, out_s1, out_s2;
    logic       strobe, strobe_s1, strobe_s2;
    logic [6:0] note, note_s1, note_s2;

    int checks = 0;
    int errors = 0;

    audio_synth #(.VOICES(2), .STEP_WIDTH(4), .OCT_MAX(5), .INTERVAL(7)) u_dut (
        .clk(clk), .rst_n(rst_n), .audio_select(sel), .hold_note(hold),
        .audio_out(out), .step_strobe(strobe), .note_idx(note));

    audio_synth #(.VOICES(1), .STEP_WIDTH(14), .OCT_MAX(5), .INTERVAL(7)) u_s1 (
        .clk(clk), .rst_n(rst_n_s), .audio_select(sel_s1), .hold_note(hold_s1),
        .audio_out(out_s1), .step_strobe(strobe_s1), .note_idx(note_s1));

    audio_synth #(.VOICES(2), .STEP_WIDTH(14), .OCT_MAX(5), .INTERVAL(7)) u_s2 (
        .clk(clk), .rst_n(rst_n_s), .audio_select(sel_s2), .hold_note(hold_s2),
        .audio_out(out_s2), .step_strobe(strobe_s2), .note_idx(note_s2));

    typedef struct {
        logic [1:0] sel;
        logic [6:0] hold;
        logic [6:0] exp_note;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for the next strobe of the fast instance; n = clocks elapsed.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strobe && n < 40);
        if (!strobe) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got no strobe after %0d clocks expected one", n);
        end
    endtask

    initial begin
        int n, rise, fall, ones, ones2;

        vecs[0]  = '{2'd1, 7'd0,   7'd1};
        vecs[1]  = '{2'd1, 7'd0,   7'd2};
        vecs[2]  = '{2'd3, 7'd100, 7'd71};
        vecs[3]  = '{2'd1, 7'd0,   7'd0};
        vecs[4]  = '{2'd1, 7'd0,   7'd1};
        vecs[5]  = '{2'd2, 7'd0,   7'd71};
        vecs[6]  = '{2'd2, 7'd0,   7'd70};
        vecs[7]  = '{2'd3, 7'd12,  7'd12};
        vecs[8]  = '{2'd2, 7'd0,   7'd71};
        vecs[9]  = '{2'd0, 7'd0,   7'd71};
        vecs[10] = '{2'd0, 7'd5,   7'd71};
        vecs[11] = '{2'd3, 7'd127, 7'd71};
        vecs[12] = '{2'd3, 7'd0,   7'd0};
        vecs[13] = '{2'd2, 7'd0,   7'd71};
        vecs[14] = '{2'd3, 7'd11,  7'd11};
        vecs[15] = '{2'd3, 7'd23,  7'd23};
        vecs[16] = '{2'd3, 7'd24,  7'd24};
        vecs[17] = '{2'd0, 7'd50,  7'd24};
        vecs[18] = '{2'd1, 7'd0,   7'd0};
        vecs[19] = '{2'd1, 7'd0,   7'd1};

        rst_n = 1'b0; rst_n_s = 1'b0;
        sel = 2'd1; hold = '0;
        sel_s1 = 2'd0; hold_s1 = '0; sel_s2 = 2'd0; hold_s2 = '0;
        repeat (3) @(negedge clk);
        check("reset_note", note, 0);
        check("reset_strobe", strobe, 0);
        check("reset_out", out, 0);
        check("reset_note_s1", note_s1, 0);

        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            sel  = vecs[i].sel;
            hold = vecs[i].hold;
            wait_step(n);
            check($sformatf("vec%0d_period", i), n, 16);
            check($sformatf("vec%0d_note", i), note, vecs[i].exp_note);
        end

        // Asynchronous reset between edges while the strobe is high.
        #2 rst_n = 1'b0;
        #1;
        check("async_note", note, 0);
        check("async_strobe", strobe, 0);
        check("async_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 2'd1;

        // Ascending from reset: first strobe after 16 clocks, top wraps to 0.
        for (int s = 1; s <= 73; s++) begin
            wait_step(n);
            check($sformatf("up%0d_period", s), n, 16);
            check($sformatf("up%0d_note", s), note, s % 72);
        end
        @(negedge clk);
        check("strobe_one_cycle", strobe, 0);

        // Descending from reset.
        rst_n = 1'b0;
        @(negedge clk);
        sel = 2'd2;
        rst_n = 1'b1;
        for (int s = 1; s <= 73; s++) begin
            wait_step(n);
            check($sformatf("down%0d_note", s), note, (s <= 72) ? 72 - s : 71);
        end

        // Slow-tempo instances: real tone periods.
        @(negedge clk);
        rst_n_s = 1'b1;
        sel_s1 = 2'd3; hold_s1 = 7'd100;
        sel_s2 = 2'd3; hold_s2 = 7'd70;
        n = 0; ones = 0;
        do begin
            @(negedge clk);
            n++;
            if (out_s1) ones++;
        end while (!strobe_s1 && n < 17000);
        check("slow_first_strobe", n, 16384);
        check("slow_quiet_before_step", ones, 0);
        check("s1_clamp_note", note_s1, 71);
        check("s2_note", note_s2, 70);

        rise = 0; fall = 0; ones2 = 0;
        for (int i = 1; i <= 4600; i++) begin
            @(negedge clk);
            if (out_s1 && rise == 0) rise = i;
            if (!out_s1 && rise != 0 && fall == 0) fall = i;
            if (out_s2) ones2++;
        end
        check("s1_first_rise", rise, 2169);
        check("s1_first_fall", fall, 4337);
        check("s2_density_ones", ones2, 1148);

        n = 4600;
        while (!out_s1 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("s1_second_rise", n, 6505);
        sel_s1 = 2'd0;
        repeat (2) @(negedge clk);
        check("mute_out", out_s1, 0);

        n = 0;
        while (!out_s2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("s2_high_before_reset", out_s2, 1);
        #2 rst_n_s = 1'b0;
        #1;
        check("async_out_s2", out_s2, 0);
        check("async_note_s2", note_s2, 0);
        check("async_strobe_s2", strobe_s2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
